// File: rtl/note_player.sv
// note_player: consumes 16-bit sequencer words. Setting words change the tempo
// (bpm); note words play a square wave on `speaker` for a number of beats.
// Beats come from a phase accumulator stepped by bpm each cycle against
// 60*CLK_HZ, so no divider is needed.
// Optional build macro ARTIC_GAP_EN: silences the last GAP_CYCLES of each note.
module note_player #(
  parameter int CLK_HZ      = 50000000,
  parameter int DEFAULT_BPM = 96,
  parameter int GAP_CYCLES  = 2500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ins_valid,
  input  logic [15:0] ins_data,
  output logic        ins_ready,
  output logic        speaker,
  output logic        playing,
  output logic [7:0]  led_note
);

  typedef enum logic {IDLE, PLAY} state_t;

  // 60*CLK_HZ overflows a signed int at 50 MHz, so build it in 64 bits.
  localparam logic [31:0] BEAT_THRESH = 32'(64'(CLK_HZ) * 64'd60);

  state_t      state_q, state_d;
  logic [11:0] bpm_q, bpm_d;
  logic [31:0] acc_q, acc_d;
  logic [19:0] cnt_q, cnt_d;
  logic [19:0] half_q, half_d;
  logic        tone_q, tone_d;
  logic        rest_q, rest_d;
  logic [4:0]  beats_q, beats_d;
  logic [7:0]  led_q, led_d;

  logic [32:0] sum;
  logic        tick;
  logic        note_acc;
  logic [4:0]  beats_load;

  // Octave-0 half periods (C1..B1) in 50 MHz cycles; deliberately not
  // rescaled by CLK_HZ. Rests (12..15) never toggle, so their entry is 0.
  function automatic logic [19:0] base_half(input logic [3:0] semi);
    case (semi)
      4'd0:    base_half = 20'd764451;
      4'd1:    base_half = 20'd721546;
      4'd2:    base_half = 20'd681049;
      4'd3:    base_half = 20'd642824;
      4'd4:    base_half = 20'd606745;
      4'd5:    base_half = 20'd572691;
      4'd6:    base_half = 20'd540549;
      4'd7:    base_half = 20'd510210;
      4'd8:    base_half = 20'd481574;
      4'd9:    base_half = 20'd454545;
      4'd10:   base_half = 20'd429034;
      4'd11:   base_half = 20'd404954;
      default: base_half = 20'd0;
    endcase
  endfunction

  assign sum        = {1'b0, acc_q} + 33'(bpm_q);
  assign tick       = (sum >= {1'b0, BEAT_THRESH});
  assign note_acc   = (state_q == IDLE) && ins_valid && ins_data[0];
  assign beats_load = (ins_data[11:8] == 4'd0) ? 5'd16 : {1'b0, ins_data[11:8]};

  assign ins_ready = (state_q == IDLE);
  assign playing   = (state_q == PLAY);
  assign led_note  = led_q;

  // Next-state: decode accepted words in IDLE; run beat and tone timing in PLAY.
  always_comb begin
    state_d = state_q;
    bpm_d   = bpm_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    tone_d  = tone_q;
    rest_d  = rest_q;
    beats_d = beats_q;
    led_d   = led_q;
    case (state_q)
      IDLE: begin
        if (ins_valid) begin
          if (!ins_data[0]) begin
            // Only opcode 000 carries a tempo; a zero tempo would stall beats.
            if (ins_data[3:1] == 3'd0 && ins_data[15:4] != 12'd0)
              bpm_d = ins_data[15:4];
          end else begin
            state_d = PLAY;
            acc_d   = '0;
            cnt_d   = '0;
            tone_d  = 1'b0;
            rest_d  = (ins_data[4:1] >= 4'd12);
            half_d  = base_half(ins_data[4:1]) >> ins_data[7:5];
            beats_d = beats_load;
            led_d   = ins_data[7:0];
          end
        end
      end
      PLAY: begin
        if (cnt_q == 20'(half_q - 20'd1)) begin
          cnt_d  = '0;
          tone_d = rest_q ? 1'b0 : ~tone_q;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
        if (tick) begin
          acc_d   = sum[31:0] - BEAT_THRESH;
          beats_d = beats_q - 5'd1;
          if (beats_q == 5'd1) begin
            state_d = IDLE;
            tone_d  = 1'b0;
            led_d   = '0;
          end
        end else begin
          acc_d = sum[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bpm_q   <= 12'(DEFAULT_BPM);
      acc_q   <= '0;
      cnt_q   <= '0;
      half_q  <= '0;
      tone_q  <= 1'b0;
      rest_q  <= 1'b0;
      beats_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      bpm_q   <= bpm_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      tone_q  <= tone_d;
      rest_q  <= rest_d;
      beats_q <= beats_d;
      led_q   <= led_d;
    end
  end

`ifdef ARTIC_GAP_EN
  // Remaining note work in accumulator units: duration*THRESH minus bpm per
  // PLAY cycle. Remaining cycles <= GAP exactly when rem <= GAP*bpm, which
  // gives the exact tail without ever dividing.
  logic [47:0] rem_q, rem_d;
  logic [47:0] gap_work;
  logic        gap_now;

  assign gap_work = 48'(GAP_CYCLES) * 48'(bpm_q);
  assign gap_now  = (state_q == PLAY) && (rem_q <= gap_work);
  assign speaker  = tone_q & ~gap_now;

  // Load on note accept, count down by bpm while playing.
  always_comb begin
    rem_d = rem_q;
    if (note_acc)
      rem_d = 48'(beats_load) * 48'(BEAT_THRESH);
    else if (state_q == PLAY)
      rem_d = (rem_q > 48'(bpm_q)) ? rem_q - 48'(bpm_q) : '0;
  end

  // Remaining-work register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rem_q <= '0;
    else        rem_q <= rem_d;
  end
`else
  logic gap_unused;
  logic note_acc_unused;
  assign gap_unused      = (GAP_CYCLES != 0);
  assign note_acc_unused = note_acc;
  assign speaker         = tone_q;
`endif

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: randomized and directed words checked against a
// cycle-count model derived from beat arithmetic (ceil of work over bpm).
module tb_note_player;
  localparam int CLK_HZ  = 1000;
  localparam int DEF_BPM = 96;
  localparam int GAP     = 300;
  localparam int THRESH  = 60 * CLK_HZ;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ins_valid = 1'b0;
  logic [15:0] ins_data = 16'h0;
  logic        ins_ready, speaker, playing;
  logic [7:0]  led_note;

  int checks = 0;
  int passes = 0;
  int model_bpm = DEF_BPM;
  int half_tab[12] = '{764451, 721546, 681049, 642824, 606745, 572691,
                       540549, 510210, 481574, 454545, 429034, 404954};

  note_player #(.CLK_HZ(CLK_HZ), .DEFAULT_BPM(DEF_BPM), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_data(ins_data),
    .ins_ready(ins_ready), .speaker(speaker), .playing(playing), .led_note(led_note)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // Present one word for a single accepting edge; ready must be high.
  task automatic send_word(input logic [15:0] w);
    @(negedge clk);
    ins_valid = 1'b1;
    ins_data  = w;
    checks++;
    if (ins_ready !== 1'b1) $display("FAIL ready_before_accept word=%h got=%b exp=1", w, ins_ready);
    else passes++;
    @(posedge clk);
    #1;
    ins_valid = 1'b0;
    if (!w[0] && w[3:1] == 3'd0 && w[15:4] != 12'd0) model_bpm = int'(w[15:4]);
  endtask

  // Play one note word and check length, speaker waveform, led and end state.
  task automatic play_note(input logic [15:0] w, input string name, output int toggles);
    int semi, oct, dur, half, k, j, spk_err, led_err, first_bad, exp_spk;
    bit rest, done;
    logic prev;
    semi = int'(w[4:1]);
    oct  = int'(w[7:5]);
    dur  = (w[11:8] == 4'd0) ? 16 : int'(w[11:8]);
    rest = (semi >= 12);
    half = rest ? 1 : (half_tab[semi] >> oct);
    k    = (dur * THRESH + model_bpm - 1) / model_bpm;
    send_word(w);
    j = 0; spk_err = 0; led_err = 0; first_bad = -1; toggles = 0; prev = 1'b0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (playing !== 1'b1) done = 1;
      else begin
        j++;
        exp_spk = rest ? 0 : (((j - 1) / half) % 2);
`ifdef ARTIC_GAP_EN
        if (k - j + 1 <= GAP) exp_spk = 0;
`endif
        if (speaker !== exp_spk[0]) begin
          spk_err++;
          if (first_bad < 0) first_bad = j;
        end
        if (led_note !== w[7:0]) led_err++;
        if (speaker !== prev) toggles++;
        prev = speaker;
        ins_data = 16'($urandom);
        if (j > k + 10) done = 1;
      end
    end
    checks++;
    if (j !== k) $display("FAIL %s play_len got=%0d exp=%0d", name, j, k);
    else passes++;
    checks++;
    if (spk_err !== 0) $display("FAIL %s speaker bad_cycles=%0d first_at=%0d exp=0", name, spk_err, first_bad);
    else passes++;
    checks++;
    if (led_err !== 0) $display("FAIL %s led_note bad_cycles=%0d exp_value=%h", name, led_err, w[7:0]);
    else passes++;
    checks++;
    if ({ins_ready, speaker, playing, led_note} !== {1'b1, 1'b0, 1'b0, 8'h00})
      $display("FAIL %s end_state got rdy=%b spk=%b play=%b led=%h exp 1 0 0 00",
               name, ins_ready, speaker, playing, led_note);
    else passes++;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({ins_ready, speaker, playing, led_note} !== {1'b1, 1'b0, 1'b0, 8'h00})
      $display("FAIL %s got rdy=%b spk=%b play=%b led=%h exp 1 0 0 00",
               name, ins_ready, speaker, playing, led_note);
    else passes++;
  endtask

  task automatic test_reset();
    int t;
    rst_n = 1'b0;
    #12;
    check_idle_outputs("reset_values");
    @(negedge clk);
    rst_n = 1'b1;
    model_bpm = DEF_BPM;
    play_note(16'h0113, "default_bpm_note", t);   // 625 cycles at bpm 96
  endtask

  task automatic test_directed_a7();
    int t;
    send_word(16'h03C0);                           // bpm 60
    play_note(16'h00F3, "a7_dur16", t);            // 16000 cycles
    checks++;
    if (t !== 4) $display("FAIL a7_toggle_count got=%0d exp=4", t);
    else passes++;
  endtask

  task automatic test_bpm600();
    int t;
    send_word(16'h2580);                           // bpm 600
    play_note(16'h02E1, "c7_dur2_bpm600", t);      // 200 cycles, led E1
  endtask

  task automatic test_rest();
    int t;
    send_word(16'h03C0);
    play_note(16'h0119, "rest_dur1", t);           // 1000 cycles silent
    checks++;
    if (t !== 0) $display("FAIL rest_toggles got=%0d exp=0", t);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int t;
    send_word(16'h12C0);                           // bpm 300
    send_word(16'h0000);                           // bpm field 0: ignored
    send_word(16'h0FF2);                           // other opcode: ignored
    send_word(16'hABC4);                           // other opcode: ignored
    play_note(16'h0133, "bpm300_after_ignored", t); // 200 cycles
    send_word(16'h0000);
    play_note(16'h02F5, "bpm300_zero_setting", t);  // 400 cycles
  endtask

  task automatic test_random();
    int t;
    logic [15:0] w;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        w = {12'($urandom_range(600, 4095)), 4'h0};
        send_word(w);
      end
      if ($urandom_range(0, 3) == 0) begin
        w = {12'($urandom), 3'($urandom_range(1, 7)), 1'b0};
        send_word(w);
      end
      w = {4'($urandom), 4'($urandom), 3'($urandom_range(3, 7)), 4'($urandom), 1'b1};
      play_note(w, $sformatf("rand%0d", i), t);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    send_word(16'h2580);
    send_word(16'h00F3);
    repeat (50) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_play");
    @(negedge clk);
    rst_n = 1'b1;
    model_bpm = DEF_BPM;
    play_note(16'h0113, "bpm_after_reset", t);     // back to 625 cycles
  endtask

  initial begin
    test_reset();
    test_directed_a7();
    test_bpm600();
    test_rest();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
